// File: rtl/mips_perf_pkg.sv
// Shared types and constants for the MIPS performance-counter unit.
// Latency/backpressure: n/a (definitions only).
package mips_perf_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_FROZEN  = 2'd2
  } perf_state_e;

  // Byte offsets from BASE_ADDR, with address bits [1:0] already dropped.
  localparam logic [4:0] OFF_CTRL  = 5'h00;
  localparam logic [4:0] OFF_TOTAL = 5'h04;
  localparam logic [4:0] OFF_STALL = 5'h08;
  localparam logic [4:0] OFF_FLUSH = 5'h0C;
  localparam logic [4:0] OFF_INSTR = 5'h10;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_FROZEN = 2;
  localparam int CTRL_OVF    = 3;

  localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

  // Field order matches the CTRL bit indices above (run is bit 0).
  typedef struct packed {
    logic [27:0] rsvd;
    logic        ovf;
    logic        frozen;
    logic        clr;
    logic        run;
  } ctrl_reg_t;

endpackage

// File: rtl/sat_counter.sv
// 32-bit saturating event counter with sticky overflow; clr beats inc.
// Latency: count updates 1 cycle after inc; no backpressure.
module sat_counter
  import mips_perf_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count,
  output logic        ovf
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (count == SAT_MAX) ovf <= 1'b1;
      else                  count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/mips_perf_ctr.sv
// Memory-mapped total/stall/flush cycle counters; optional INSTR counter under PERF_INSTR_CNT_EN.
// Latency: reads combinational, CTRL writes take effect at the sampling edge; no backpressure.
module mips_perf_ctr
  import mips_perf_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_D,
  input  logic        flush_E,
  input  logic        instr_retire,
  input  logic        halt,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic [31:0] total_cycles,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
);

  perf_state_e state;
  ctrl_reg_t   ctrl_rd;
  logic [4:0]  off;
  logic        counting;
  logic        ctrl_wr;
  logic        clr;
  logic        total_ovf, stall_ovf, flush_ovf, instr_ovf;
  logic        ovf_any;
  logic [31:0] instr_count;

  assign off      = {addr[4:2], 2'b00};
  assign hit      = (addr[31:5] == BASE_ADDR[31:5]);
  assign ctrl_wr  = hit && we && (off == OFF_CTRL);
  assign clr      = ctrl_wr && wdata[CTRL_CLR];
  assign counting = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else if (ctrl_wr) begin
      // Re-arming while the core is still halted goes straight back to FROZEN.
      if (wdata[CTRL_RUN]) state <= halt ? ST_FROZEN : ST_RUN;
      else                 state <= ST_STOPPED;
    end else if (state == ST_RUN && halt) begin
      state <= ST_FROZEN;
    end
  end

  sat_counter u_total (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (counting),
    .count (total_cycles),
    .ovf   (total_ovf)
  );

  sat_counter u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (counting && stall_D),
    .count (stall_cycles),
    .ovf   (stall_ovf)
  );

  sat_counter u_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (counting && flush_E),
    .count (flush_cycles),
    .ovf   (flush_ovf)
  );

`ifdef PERF_INSTR_CNT_EN
  sat_counter u_instr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (counting && instr_retire),
    .count (instr_count),
    .ovf   (instr_ovf)
  );
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
  assign instr_count   = '0;
  assign instr_ovf     = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:2]};

  assign ovf_any = total_ovf || stall_ovf || flush_ovf || instr_ovf;

  always_comb begin
    ctrl_rd        = '0;
    ctrl_rd.run    = (state != ST_STOPPED);
    ctrl_rd.frozen = (state == ST_FROZEN);
    ctrl_rd.ovf    = ovf_any;
    rdata          = '0;
    if (hit) begin
      case (off)
        OFF_CTRL:  rdata = ctrl_rd;
        OFF_TOTAL: rdata = total_cycles;
        OFF_STALL: rdata = stall_cycles;
        OFF_FLUSH: rdata = flush_cycles;
        OFF_INSTR: rdata = instr_count;
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_perf_ctr.sv
// Directed bench for mips_perf_ctr; define PERF_INSTR_CNT_EN to exercise the INSTR counter.
module tb_mips_perf_ctr;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_D, flush_E, instr_retire, halt, we;
  logic [31:0] addr, wdata;
  logic        hit;
  logic [31:0] rdata, total_cycles, stall_cycles, flush_cycles;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #50 clk = ~clk;

  mips_perf_ctr #(.BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_D      (stall_D),
    .flush_E      (flush_E),
    .instr_retire (instr_retire),
    .halt         (halt),
    .addr         (addr),
    .we           (we),
    .wdata        (wdata),
    .hit          (hit),
    .rdata        (rdata),
    .total_cycles (total_cycles),
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] off, output logic [31:0] val);
    addr = BASE + {27'd0, off};
    we   = 1'b0;
    #1;
    val  = rdata;
    addr = IDLE_ADDR;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] val);
    addr  = BASE + {27'd0, off};
    we    = 1'b1;
    wdata = val;
    step(1);
    we    = 1'b0;
    wdata = '0;
    addr  = IDLE_ADDR;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; stall_D = 1'b0; flush_E = 1'b0; halt = 1'b0; instr_retire = 1'b0;
    addr = IDLE_ADDR; we = 1'b0; wdata = '0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    do_reset;
    stall_D = 1'b1; flush_E = 1'b1;
    step(5);
    rst_n = 1'b0;
    step(1);
    stall_D = 1'b0; flush_E = 1'b0;
    cmp_cnt++; if (total_cycles !== 32'd0) begin err_cnt++; $display("FAIL reset_total: got %0d expected 0", total_cycles); end
    cmp_cnt++; if (stall_cycles !== 32'd0) begin err_cnt++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
    cmp_cnt++; if (flush_cycles !== 32'd0) begin err_cnt++; $display("FAIL reset_flush: got %0d expected 0", flush_cycles); end
    rd(5'h00, v);
    cmp_cnt++; if (v !== 32'h1) begin err_cnt++; $display("FAIL reset_ctrl: got %h expected 00000001", v); end
    #1;
    cmp_cnt++; if (hit !== 1'b0 || rdata !== 32'd0) begin err_cnt++; $display("FAIL reset_nohit: got hit=%b rdata=%h expected hit=0 rdata=0", hit, rdata); end
  endtask

  task automatic test_idle_count;
    logic [31:0] v;
    do_reset;
    step(100);
    rd(5'h04, v);
    cmp_cnt++; if (v !== 32'd100) begin err_cnt++; $display("FAIL idle_total: got %0d expected 100", v); end
    rd(5'h08, v);
    cmp_cnt++; if (v !== 32'd0) begin err_cnt++; $display("FAIL idle_stall: got %0d expected 0", v); end
    rd(5'h0C, v);
    cmp_cnt++; if (v !== 32'd0) begin err_cnt++; $display("FAIL idle_flush: got %0d expected 0", v); end
    rd(5'h00, v);
    cmp_cnt++; if (v !== 32'h1) begin err_cnt++; $display("FAIL idle_ctrl: got %h expected 00000001", v); end
    cmp_cnt++; if (total_cycles !== 32'd100) begin err_cnt++; $display("FAIL idle_total_port: got %0d expected 100", total_cycles); end
  endtask

  task automatic test_stall_flush;
    logic [31:0] v;
    do_reset;
    for (int i = 0; i < 50; i++) begin
      stall_D = (i inside {3, 10, 11, 20, 27, 33, 45});
      flush_E = (i inside {10, 20, 40});
      step(1);
    end
    stall_D = 1'b0; flush_E = 1'b0;
    rd(5'h04, v);
    cmp_cnt++; if (v !== 32'd50) begin err_cnt++; $display("FAIL sf_total: got %0d expected 50", v); end
    rd(5'h08, v);
    cmp_cnt++; if (v !== 32'd7) begin err_cnt++; $display("FAIL sf_stall: got %0d expected 7", v); end
    rd(5'h0C, v);
    cmp_cnt++; if (v !== 32'd3) begin err_cnt++; $display("FAIL sf_flush: got %0d expected 3", v); end
    cmp_cnt++; if (stall_cycles !== 32'd7 || flush_cycles !== 32'd3) begin err_cnt++; $display("FAIL sf_ports: got stall=%0d flush=%0d expected 7 3", stall_cycles, flush_cycles); end
  endtask

  task automatic test_halt;
    logic [31:0] v;
    do_reset;
    step(39);
    halt = 1'b1;
    step(21);
    rd(5'h04, v);
    cmp_cnt++; if (v !== 32'd40) begin err_cnt++; $display("FAIL halt_total: got %0d expected 40", v); end
    rd(5'h00, v);
    cmp_cnt++; if (v !== 32'h5) begin err_cnt++; $display("FAIL halt_ctrl: got %h expected 00000005", v); end
    wr(5'h00, 32'h1);
    rd(5'h00, v);
    cmp_cnt++; if (v !== 32'h5) begin err_cnt++; $display("FAIL halt_rearm_ctrl: got %h expected 00000005", v); end
    step(3);
    rd(5'h04, v);
    cmp_cnt++; if (v !== 32'd40) begin err_cnt++; $display("FAIL halt_frozen_total: got %0d expected 40", v); end
    halt = 1'b0;
    wr(5'h00, 32'h1);
    rd(5'h00, v);
    cmp_cnt++; if (v !== 32'h1) begin err_cnt++; $display("FAIL halt_resume_ctrl: got %h expected 00000001", v); end
    step(3);
    rd(5'h04, v);
    cmp_cnt++; if (v !== 32'd43) begin err_cnt++; $display("FAIL halt_resume_total: got %0d expected 43", v); end
  endtask

  task automatic test_stop_resume;
    logic [31:0] v;
    do_reset;
    step(9);
    wr(5'h00, 32'h0);
    step(20);
    rd(5'h00, v);
    cmp_cnt++; if (v !== 32'h0) begin err_cnt++; $display("FAIL stop_ctrl: got %h expected 00000000", v); end
    rd(5'h04, v);
    cmp_cnt++; if (v !== 32'd10) begin err_cnt++; $display("FAIL stop_total: got %0d expected 10", v); end
    wr(5'h00, 32'h1);
    step(5);
    rd(5'h04, v);
    cmp_cnt++; if (v !== 32'd15) begin err_cnt++; $display("FAIL resume_total: got %0d expected 15", v); end
    wr(5'h04, 32'h2);
    rd(5'h04, v);
    cmp_cnt++; if (v !== 32'd16) begin err_cnt++; $display("FAIL ro_write_total: got %0d expected 16", v); end
    stall_D = 1'b1;
    wr(5'h00, 32'h3);
    stall_D = 1'b0;
    cmp_cnt++; if (total_cycles !== 32'd0 || stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
      err_cnt++; $display("FAIL clr_wins: got total=%0d stall=%0d flush=%0d expected 0 0 0", total_cycles, stall_cycles, flush_cycles);
    end
    step(1);
    cmp_cnt++; if (total_cycles !== 32'd1) begin err_cnt++; $display("FAIL clr_then_run: got %0d expected 1", total_cycles); end
  endtask

  task automatic test_saturate;
    logic [31:0] v;
    do_reset;
    step(2);
    force dut.u_total.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_total.count;
    step(3);
    rd(5'h04, v);
    cmp_cnt++; if (v !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL sat_total: got %h expected ffffffff", v); end
    rd(5'h00, v);
    cmp_cnt++; if (v !== 32'h9) begin err_cnt++; $display("FAIL sat_ovf_ctrl: got %h expected 00000009", v); end
    wr(5'h00, 32'h3);
    rd(5'h04, v);
    cmp_cnt++; if (v !== 32'd0) begin err_cnt++; $display("FAIL sat_clr_total: got %h expected 00000000", v); end
    rd(5'h00, v);
    cmp_cnt++; if (v !== 32'h1) begin err_cnt++; $display("FAIL sat_clr_ctrl: got %h expected 00000001", v); end
  endtask

  task automatic test_reg_map;
    logic [31:0] v;
    do_reset;
    step(4);
    rd(5'h14, v);
    cmp_cnt++; if (v !== 32'd0) begin err_cnt++; $display("FAIL map_14: got %h expected 0", v); end
    rd(5'h1C, v);
    cmp_cnt++; if (v !== 32'd0) begin err_cnt++; $display("FAIL map_1c: got %h expected 0", v); end
    addr = BASE + 32'h20; #1;
    cmp_cnt++; if (hit !== 1'b0 || rdata !== 32'd0) begin err_cnt++; $display("FAIL map_above: got hit=%b rdata=%h expected 0 0", hit, rdata); end
    addr = BASE - 32'h4; #1;
    cmp_cnt++; if (hit !== 1'b0 || rdata !== 32'd0) begin err_cnt++; $display("FAIL map_below: got hit=%b rdata=%h expected 0 0", hit, rdata); end
    addr = BASE + 32'h5; #1;
    cmp_cnt++; if (hit !== 1'b1 || rdata !== 32'd4) begin err_cnt++; $display("FAIL map_unaligned: got hit=%b rdata=%0d expected 1 4", hit, rdata); end
    addr = IDLE_ADDR;
  endtask

  task automatic test_instr;
    logic [31:0] v;
    do_reset;
`ifdef PERF_INSTR_CNT_EN
    for (int i = 0; i < 20; i++) begin
      instr_retire = ((i % 5) < 3);
      step(1);
    end
    instr_retire = 1'b0;
    rd(5'h10, v);
    cmp_cnt++; if (v !== 32'd12) begin err_cnt++; $display("FAIL instr_count: got %0d expected 12", v); end
    wr(5'h00, 32'h3);
    rd(5'h10, v);
    cmp_cnt++; if (v !== 32'd0) begin err_cnt++; $display("FAIL instr_clr: got %0d expected 0", v); end
`else
    instr_retire = 1'b1;
    step(10);
    instr_retire = 1'b0;
    rd(5'h10, v);
    cmp_cnt++; if (v !== 32'd0) begin err_cnt++; $display("FAIL instr_absent: got %0d expected 0", v); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; stall_D = 1'b0; flush_E = 1'b0; halt = 1'b0; instr_retire = 1'b0;
    addr = IDLE_ADDR; we = 1'b0; wdata = '0;
    @(negedge clk);
    test_reset;
    test_idle_count;
    test_stall_flush;
    test_halt;
    test_stop_resume;
    test_saturate;
    test_reg_map;
    test_instr;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_perf_ctr.md
# mips_perf_ctr

Performance-counter unit for the pipelined MIPS core. It counts total, stall and flush cycles from hazard-unit events. It also exposes the counts as word-aligned memory-mapped registers that software running on the core can read, clear and gate. It drives the top-level `total_cycles` / `stall_cycles` / `flush_cycles` outputs and sits beside the data memory on the core's load/store path.

## Interface
- `BASE_ADDR`, default 32'hFFFF_FF00: byte address of register 0; the block decodes `BASE_ADDR` to `BASE_ADDR+0x1F`.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `stall_D`  in  1: decode-stage stall from the hazard unit.
- `flush_E`  in  1: execute-stage flush from the hazard unit.
- `instr_retire`  in  1: writeback-stage valid instruction; used only with the macro enabled.
- `halt`  in  1: level; core has reached its end condition.
- `addr`  in  32: data-memory-stage byte address.
- `we`  in  1: store strobe for the address in `addr`.
- `wdata`  in  32: store data.
- `hit`  out  1: `addr` is in the block's range (bits [1:0] ignored); the core muxes `rdata` in only when `hit` is high.
- `rdata`  out  32: combinational read data.
- `total_cycles`, `stall_cycles`, `flush_cycles`  out  32 each: live counter values.

## Operation
- States are STOPPED, RUN and FROZEN. Reset sets the state to RUN, so counting starts on the first edge after `rst_n` rises.
- On every edge where the registered state is RUN:
  - `total` increments by 1.
  - `stall` increments if `stall_D` is high.
  - `flush` increments if `flush_E` is high.
  - `stall` and `flush` both increment when both inputs are high.
- Counters saturate at 32'hFFFF_FFFF and never wrap. A sticky `OVF` bit is set when any counter attempts to pass its saturation value.
- RUN + `halt` → FROZEN. The halting cycle itself is counted.
- FROZEN ignores `halt`. It leaves FROZEN only through a CTRL write.
- Register map, offset from `BASE_ADDR`:
  - 0x00 CTRL:
    - bit0 RUN: read/write.
    - bit1 CLR: write-1 clears all counters and `OVF`; reads 0.
    - bit2 FROZEN: read-only.
    - bit3 OVF: read-only.
  - 0x04 TOTAL, 0x08 STALL, 0x0C FLUSH: read-only; writes are ignored.
  - 0x10 INSTR: see Configuration.
  - 0x14–0x1C: read 0.
- CTRL write transitions:
  - RUN=0 → STOPPED.
  - RUN=1 → RUN, from either STOPPED or FROZEN.
  - RUN=1 written while `halt` is high → FROZEN.
- Simultaneous events:
  - CLR and an increment on the same edge: CLR wins, and the counter is 0 after the edge.
  - CLR with RUN=1 in the same write: counters clear and the state becomes RUN.
- `rdata` is 0 when `hit` is low.

## Timing
- Reset values, after the first edge with `rst_n` low:
  - all counters 0;
  - `OVF` 0;
  - state RUN;
  - `rdata` 0 unless `hit`.
- A reset during operation behaves identically and discards all counts.
- Read latency is 0 cycles. `rdata` reflects counter values registered at the previous edge, so a load in cycle N returns the count through edge N.
- Write effect is 1 cycle: the CTRL write takes effect at the same edge that samples `we`. The state change is visible to counting from the next edge.
- `total_cycles`, `stall_cycles` and `flush_cycles` are register outputs with no combinational path from the inputs.

## Configuration
- `PERF_INSTR_CNT_EN` defined:
  - Adds a 32-bit saturating `instr` counter, incremented when the state is RUN and `instr_retire` is high.
  - It is readable at 0x10, cleared by CLR, and contributes to `OVF`.
- Macro undefined:
  - No `instr` register is built; 0x10 reads 0.
  - `instr_retire` is unused.

## Structure
- Shared package `mips_perf_pkg` holds:
  - the state enum (STOPPED/RUN/FROZEN);
  - register offsets;
  - CTRL bit indices;
  - the saturation constant 32'hFFFF_FFFF.
- One sub-module, `sat_counter`: a 32-bit saturating counter with inputs `clr` and `inc` and outputs `count` and `ovf`.
  - It is instantiated 3 times, or 4 with `PERF_INSTR_CNT_EN` defined.
  - `clr` has priority over `inc`.

## Test plan
- Reset, then 100 edges with `stall_D`/`flush_E` low → TOTAL=100, STALL=0, FLUSH=0, CTRL reads 0x1.
- `stall_D` high on 7 edges and `flush_E` high on 3 edges, 2 of them overlapping, within 50 edges → TOTAL=50, STALL=7, FLUSH=3.
- `halt` raised at edge 40 and held for 20 more edges → TOTAL=40, CTRL reads 0x5; writing CTRL=0x1 while `halt` is still high leaves the state FROZEN.
- Write CTRL=0x0 at edge 10, wait 20 edges, write CTRL=0x1, wait 5 edges → TOTAL=15; CTRL=0x3 issued on an edge with `stall_D` high → every counter reads 0 on the following edge.
- Force TOTAL to 32'hFFFF_FFFE, run 3 edges → TOTAL=32'hFFFF_FFFF, OVF=1; CLR clears both.
- With `PERF_INSTR_CNT_EN` defined, retire 12 instructions in 20 edges → INSTR=12; with the macro undefined, a read of 0x10 returns 0.
